// File: rtl/average_decimator_pkg.sv
// Shared constants for the average filter output stages.
// Sample width and FIFO pointer sizing used by the decimator and its FIFO.
package average_decimator_pkg;

   localparam int unsigned AD_DW = 8;

   // Pointer width carries one extra MSB so full and empty can be told apart.
   function automatic int unsigned fifo_ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/average_decimator_sync_fifo.sv
// Synchronous FIFO with registered head, valid and level outputs.
// The head register holds its last value while the FIFO is empty.
module sync_fifo
   import average_decimator_pkg::*;
#(
   parameter int unsigned DW    = AD_DW,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [DW-1:0]            i_data,
   output logic [DW-1:0]            o_data,
   output logic                     o_valid,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = fifo_ptr_w(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW-1:0] PTR_ZERO = PW'(0);

   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_next_s;
   logic [PW-1:0] rd_ptr_next_s;
   logic [PW-1:0] level_next_s;
   logic [PW-1:0] level_r;
   logic [AW-1:0] wr_idx_s;
   logic [AW-1:0] rd_next_idx_s;
   logic [DW-1:0] mem_r [DEPTH];
   logic [DW-1:0] data_r;
   logic [DW-1:0] data_next_s;
   logic          valid_r;
   logic          empty_s;
   logic          full_s;
   logic          push_s;
   logic          pop_s;

   // Pointer arithmetic, occupancy and next head value.
   always_comb begin
      empty_s  = (wr_ptr_r == rd_ptr_r);
      full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      pop_s    = i_pop && !empty_s;
      push_s   = i_push && (!full_s || pop_s);
      wr_idx_s = wr_ptr_r[AW-1:0];
      if (push_s) begin
         wr_ptr_next_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_next_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_next_s = rd_ptr_r;
      end
      rd_next_idx_s = rd_ptr_next_s[AW-1:0];
      level_next_s  = wr_ptr_next_s - rd_ptr_next_s;
      // A sample written into the slot that becomes the head is taken straight from i_data.
      if (level_next_s == PTR_ZERO) begin
         data_next_s = data_r;
      end else if (push_s && (wr_idx_s == rd_next_idx_s)) begin
         data_next_s = i_data;
      end else begin
         data_next_s = mem_r[rd_next_idx_s];
      end
   end

   // Pointers and registered head/valid/level.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         level_r  <= PTR_ZERO;
         valid_r  <= 1'b0;
         data_r   <= {DW{1'b0}};
      end else begin
         wr_ptr_r <= wr_ptr_next_s;
         rd_ptr_r <= rd_ptr_next_s;
         level_r  <= level_next_s;
         valid_r  <= (level_next_s != PTR_ZERO);
         data_r   <= data_next_s;
      end
   end

   // Storage array; contents are only read once written, so it needs no reset.
   always_ff @(posedge i_clk) begin
      if (push_s) begin
         mem_r[wr_idx_s] <= i_data;
      end
   end

   assign o_data  = data_r;
   assign o_valid = valid_r;
   assign o_full  = full_s;
   assign o_empty = empty_s;
   assign o_level = level_r;

endmodule

// File: rtl/average_decimator.sv
// Pick decimator behind the average filter: keeps every DECIM-th enabled sample,
// buffers it in a FIFO and raises a sticky overflow flag when a kept sample is lost.
module average_decimator
   import average_decimator_pkg::*;
#(
   parameter int unsigned DW    = AD_DW,
   parameter int unsigned DECIM = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_en,
   input  logic [DW-1:0]            i_data,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [DW-1:0]            o_data,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_overflow,
   input  logic                     i_clear_ovf
);

   localparam int unsigned PHW = $clog2(DECIM);
   localparam logic [PHW-1:0] PHASE_LAST = PHW'(DECIM - 1);
   localparam logic [PHW-1:0] PHASE_ONE  = PHW'(1);
   localparam logic [PHW-1:0] PHASE_ZERO = PHW'(0);

   logic [PHW-1:0] phase_r;
   logic [PHW-1:0] phase_next_s;
   logic           keep_s;
   logic           pop_s;
   logic           drop_s;
   logic           ovf_r;
   logic           ovf_next_s;
   logic           fifo_valid_s;
   logic           fifo_full_s;
   logic           fifo_empty_s;

   // Phase advance, keep decision and overflow flag update.
   always_comb begin
      keep_s = i_en && (phase_r == PHASE_LAST);
      pop_s  = fifo_valid_s && !fifo_empty_s && i_ready;
      drop_s = keep_s && fifo_full_s && !pop_s;
      if (i_en) begin
         if (phase_r == PHASE_LAST) begin
            phase_next_s = PHASE_ZERO;
         end else begin
            phase_next_s = phase_r + PHASE_ONE;
         end
      end else begin
         phase_next_s = phase_r;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop_s) begin
         ovf_next_s = 1'b1;
      end else if (i_clear_ovf) begin
         ovf_next_s = 1'b0;
      end else begin
         ovf_next_s = ovf_r;
      end
   end

   // Phase counter and sticky overflow register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         phase_r <= PHASE_ZERO;
         ovf_r   <= 1'b0;
      end else begin
         phase_r <= phase_next_s;
         ovf_r   <= ovf_next_s;
      end
   end

   sync_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_push    (keep_s),
      .i_pop     (pop_s),
      .i_data    (i_data),
      .o_data    (o_data),
      .o_valid   (fifo_valid_s),
      .o_full    (fifo_full_s),
      .o_empty   (fifo_empty_s),
      .o_level   (o_level)
   );

   assign o_valid    = fifo_valid_s;
   assign o_overflow = ovf_r;

endmodule

// File: tb/tb_average_decimator.sv
// Self-checking bench: a default build (DECIM=4, DEPTH=4) and a small build
// (DECIM=2, DEPTH=2) share one stimulus stream, each tracked by its own queue model.
module tb_average_decimator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       clr;
   logic       rdy;
   logic [7:0] din;

   logic       v0, ov0, v1, ov1;
   logic [7:0] d0, d1;
   logic [2:0] l0;
   logic [1:0] l1;

   int errs   = 0;
   int checks = 0;

   int         m_phase [2];
   logic       m_ovf   [2];
   logic [7:0] m_last  [2];
   logic [7:0] mq      [2][$];

   always #5 clk = ~clk;

   average_decimator #(.DW(8), .DECIM(4), .DEPTH(4)) dut0 (
      .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_data(din), .o_valid(v0),
      .i_ready(rdy), .o_data(d0), .o_level(l0), .o_overflow(ov0), .i_clear_ovf(clr)
   );

   average_decimator #(.DW(8), .DECIM(2), .DEPTH(2)) dut1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_data(din), .o_valid(v1),
      .i_ready(rdy), .o_data(d1), .o_level(l1), .o_overflow(ov1), .i_clear_ovf(clr)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs(input int k);
      logic [31:0] v, l, o, d, exp_d;
      int          n;
      if (k == 0) begin
         v = 32'(v0); l = 32'(l0); o = 32'(ov0); d = 32'(d0);
      end else begin
         v = 32'(v1); l = 32'(l1); o = 32'(ov1); d = 32'(d1);
      end
      n = mq[k].size();
      exp_d = (n != 0) ? 32'(mq[k][0]) : 32'(m_last[k]);
      check_val($sformatf("valid%0d", k), v, (n != 0) ? 32'd1 : 32'd0);
      check_val($sformatf("level%0d", k), l, 32'(n));
      check_val($sformatf("ovf%0d", k), o, 32'(m_ovf[k]));
      check_val($sformatf("data%0d", k), d, exp_d);
   endtask

   task automatic model_step(input int k, input logic e, input logic [7:0] d,
                             input logic r, input logic c);
      int   dec, dep;
      logic keep, pop, drop;
      dec  = (k == 0) ? 4 : 2;
      dep  = (k == 0) ? 4 : 2;
      keep = e && (m_phase[k] == dec - 1);
      pop  = r && (mq[k].size() != 0);
      drop = keep && !pop && (mq[k].size() == dep);
      if (pop) m_last[k] = mq[k].pop_front();
      if (keep && !drop) mq[k].push_back(d);
      if (drop) m_ovf[k] = 1'b1;
      else if (c) m_ovf[k] = 1'b0;
      if (e) m_phase[k] = (m_phase[k] == dec - 1) ? 0 : m_phase[k] + 1;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_phase[k] = 0;
         m_ovf[k]   = 1'b0;
         m_last[k]  = 8'd0;
         mq[k].delete();
      end
   endtask

   task automatic cyc(input logic e, input logic [7:0] d, input logic r, input logic c);
      @(negedge clk);
      en = e; din = d; rdy = r; clr = c;
      #1;
      check_outputs(0);
      check_outputs(1);
      model_step(0, e, d, r, c);
      model_step(1, e, d, r, c);
   endtask

   // Asserts reset between clock edges and checks outputs clear immediately.
   task automatic do_reset();
      @(negedge clk);
      en = 1'b0; rdy = 1'b0; clr = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_valid0", 32'(v0), 32'd0);
      check_val("rst_level0", 32'(l0), 32'd0);
      check_val("rst_data0",  32'(d0), 32'd0);
      check_val("rst_ovf0",   32'(ov0), 32'd0);
      check_val("rst_valid1", 32'(v1), 32'd0);
      check_val("rst_level1", 32'(l1), 32'd0);
      check_val("rst_data1",  32'(d1), 32'd0);
      check_val("rst_ovf1",   32'(ov1), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; din = 8'd0; rdy = 1'b0; clr = 1'b0;
      model_reset();
      do_reset();

      for (int i = 1; i <= 12; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);

      cyc(1'b1, 8'd10, 1'b1, 1'b0); cyc(1'b0, 8'd99, 1'b1, 1'b0);
      cyc(1'b1, 8'd11, 1'b1, 1'b0); cyc(1'b0, 8'd99, 1'b1, 1'b0);
      cyc(1'b1, 8'd12, 1'b1, 1'b0); cyc(1'b0, 8'd99, 1'b1, 1'b0);
      cyc(1'b1, 8'd13, 1'b1, 1'b0);
      @(posedge clk); #1;
      check_val("toggle_keep13", 32'(d0), 32'd13);
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      cyc(1'b0, 8'd0, 1'b1, 1'b0);

      for (int i = 1; i <= 19; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
      @(posedge clk); #1;
      check_val("full_level", 32'(l0), 32'd4);
      check_val("full_head",  32'(d0), 32'd4);
      cyc(1'b1, 8'd20, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_val("drop_ovf",   32'(ov0), 32'd1);
      check_val("drop_head",  32'(d0), 32'd4);
      check_val("drop_level", 32'(l0), 32'd4);
      cyc(1'b0, 8'd0, 1'b0, 1'b1);
      @(posedge clk); #1;
      check_val("clear_ovf",  32'(ov0), 32'd0);

      for (int i = 21; i <= 23; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
      cyc(1'b1, 8'd24, 1'b1, 1'b0);
      @(posedge clk); #1;
      check_val("fullpop_level", 32'(l0), 32'd4);
      check_val("fullpop_ovf",   32'(ov0), 32'd0);
      check_val("fullpop_head",  32'(d0), 32'd8);
      for (int i = 0; i < 6; i++) cyc(1'b0, 8'd0, 1'b1, 1'b0);

      for (int i = 1; i <= 14; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
      @(posedge clk); #1;
      check_val("pre_rst_level", 32'(l0), 32'd3);
      do_reset();
      for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i + 40), 1'b1, 1'b0);
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      cyc(1'b0, 8'd0, 1'b1, 1'b0);

      do_reset();
      for (int i = 5; i <= 10; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
      @(posedge clk); #1;
      check_val("small_level", 32'(l1), 32'd2);
      check_val("small_head",  32'(d1), 32'd6);
      check_val("small_ovf",   32'(ov1), 32'd1);
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 1'b1, 1'b0);
      @(posedge clk); #1;
      check_val("small_last",  32'(d1), 32'd8);
      check_val("small_empty", 32'(v1), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
